// File: rtl/axi4_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_pkg
// Shared AXI4-Lite definitions for the register-slave family: response codes
// and the write/read handshake state encodings.
// ---------------------------------------------------------------------------
package axi4_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage : axi4_lite_pkg

// File: rtl/axi4_lite_wstrb_merge.sv
// ---------------------------------------------------------------------------
// axi4_lite_wstrb_merge
// Combinational byte merge: each byte lane takes the new data when its strobe
// is set, otherwise keeps the old data.
// Ports:
//   i_old     DATA_WIDTH    current register value
//   i_new     DATA_WIDTH    write data
//   i_strb    DATA_WIDTH/8  byte strobes
//   o_merged  DATA_WIDTH    merged result
// ---------------------------------------------------------------------------
module axi4_lite_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_new,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  output logic [DATA_WIDTH-1:0]   o_merged
);

  // Per-lane select between old and new byte
  always_comb begin
    o_merged = i_old;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (i_strb[b]) begin
        o_merged[8*b +: 8] = i_new[8*b +: 8];
      end else begin
        o_merged[8*b +: 8] = i_old[8*b +: 8];
      end
    end
  end

endmodule : axi4_lite_wstrb_merge

// File: rtl/axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_reg_slave
// AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers. One
// outstanding write and one outstanding read.
// Optional feature macro: AXIL_REG_SLVERR_EN -- out-of-range accesses answer
// SLVERR instead of OKAY (writes are discarded and reads return 0 either way).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*           write address / data / response channels
//   s_ar*/s_r*                read address / data channels
//   regs_o    NUM_REGS*32     register contents, reg k at [32k+31:32k]
//   reg_wr_o  NUM_REGS        one-cycle pulse the cycle after reg k is written
// ---------------------------------------------------------------------------
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      s_awaddr,
  input  logic [2:0]                 s_awprot,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [DATA_WIDTH-1:0]      s_wdata,
  input  logic [DATA_WIDTH/8-1:0]    s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [ADDR_WIDTH-1:0]      s_araddr,
  input  logic [2:0]                 s_arprot,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [DATA_WIDTH-1:0]      s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [NUM_REGS*32-1:0]     regs_o,
  output logic [NUM_REGS-1:0]        reg_wr_o
);

  localparam int IDX_W  = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1;
  // Word-address field: addr[ADDR_WIDTH-5:2] (top nibble belongs to the interconnect)
  localparam int WORD_W = ADDR_WIDTH - 6;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);

  wr_state_e               r_wstate;
  rd_state_e               r_rstate;
  logic                    r_aw_hold;
  logic [WORD_W-1:0]       r_aw_word;
  logic                    r_w_hold;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic                    r_bvalid;
  axi_resp_t               r_bresp;
  logic                    r_rvalid;
  axi_resp_t               r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]     r_reg_wr;

  logic                    w_awready;
  logic                    w_wready;
  logic                    w_arready;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_ar_hs;
  logic                    w_commit;
  logic [WORD_W-1:0]       w_aw_word;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [STRB_W-1:0]       w_wstrb;
  logic                    w_wr_oor;
  logic [IDX_W-1:0]        w_wr_idx;
  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [WORD_W-1:0]       w_ar_word;
  logic                    w_rd_oor;
  logic [IDX_W-1:0]        w_rd_idx;
  axi_resp_t               w_bresp_nxt;
  axi_resp_t               w_rresp_nxt;
  logic                    w_unused_bits;

  // Readies drop while a response is pending and are forced low during reset
  assign w_awready = !rst && !r_aw_hold && !r_bvalid;
  assign w_wready  = !rst && !r_w_hold  && !r_bvalid;
  assign w_arready = !rst && !r_rvalid;

  assign w_aw_hs = s_awvalid && w_awready;
  assign w_w_hs  = s_wvalid  && w_wready;
  assign w_ar_hs = s_arvalid && w_arready;

  // Take held AW/W values when present, otherwise the live bus
  always_comb begin
    if (r_aw_hold) begin
      w_aw_word = r_aw_word;
    end else begin
      w_aw_word = s_awaddr[ADDR_WIDTH-5:2];
    end
    if (r_w_hold) begin
      w_wdata = r_wdata;
      w_wstrb = r_wstrb;
    end else begin
      w_wdata = s_wdata;
      w_wstrb = s_wstrb;
    end
  end

  assign w_commit  = (r_wstate == W_IDLE) && (r_aw_hold || w_aw_hs) && (r_w_hold || w_w_hs);
  assign w_wr_oor  = (w_aw_word >= NUM_REGS_W);
  assign w_wr_idx  = w_aw_word[IDX_W-1:0];
  assign w_old     = r_regs[w_wr_idx];
  assign w_ar_word = s_araddr[ADDR_WIDTH-5:2];
  assign w_rd_oor  = (w_ar_word >= NUM_REGS_W);
  assign w_rd_idx  = w_ar_word[IDX_W-1:0];

`ifdef AXIL_REG_SLVERR_EN
  assign w_bresp_nxt = w_wr_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign w_rresp_nxt = w_rd_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
  assign w_bresp_nxt = AXI_RESP_OKAY;
  assign w_rresp_nxt = AXI_RESP_OKAY;
`endif

  // Address bits decoded by the interconnect, byte offsets and prot are ignored
  assign w_unused_bits = ^{s_awprot, s_arprot,
                           s_awaddr[ADDR_WIDTH-1:ADDR_WIDTH-4], s_awaddr[1:0],
                           s_araddr[ADDR_WIDTH-1:ADDR_WIDTH-4], s_araddr[1:0]};

  axi4_lite_wstrb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .i_old    (w_old),
    .i_new    (w_wdata),
    .i_strb   (w_wstrb),
    .o_merged (w_merged)
  );

  // Write FSM: collect AW and W independently, commit, then hold B until bready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_hold <= 1'b0;
      r_aw_word <= '0;
      r_w_hold  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_aw_hold <= 1'b0;
            r_w_hold  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_bresp_nxt;
            r_wstate  <= W_RESP;
          end else begin
            if (w_aw_hs) begin
              r_aw_hold <= 1'b1;
              r_aw_word <= s_awaddr[ADDR_WIDTH-5:2];
            end
            if (w_w_hs) begin
              r_w_hold <= 1'b1;
              r_wdata  <= s_wdata;
              r_wstrb  <= s_wstrb;
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: begin
          r_bvalid <= 1'b0;
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Register file update and per-register write pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
      r_reg_wr <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_commit && !w_wr_oor && (w_wr_idx == IDX_W'(k))) begin
          r_regs[k]   <= w_merged;
          r_reg_wr[k] <= 1'b1;
        end else begin
          r_reg_wr[k] <= 1'b0;
        end
      end
    end
  end

  // Read FSM: capture data on AR handshake (pre-write value on a same-edge commit)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= AXI_RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata  <= w_rd_oor ? '0 : r_regs[w_rd_idx];
            r_rresp  <= w_rresp_nxt;
            r_rvalid <= 1'b1;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            r_rvalid <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: begin
          r_rvalid <= 1'b0;
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  // Flatten the register array onto the fabric-side bus
  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[k*32 +: 32] = r_regs[k];
    end
  end

  assign s_awready = w_awready;
  assign s_wready  = w_wready;
  assign s_arready = w_arready;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;
  assign reg_wr_o  = r_reg_wr;

endmodule : axi4_lite_reg_slave

// File: tb/tb_axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_reg_slave
// Directed self-checking bench for axi4_lite_reg_slave (NUM_REGS=8).
// ---------------------------------------------------------------------------
module tb_axi4_lite_reg_slave;

  logic          clk;
  logic          rst;
  logic [31:0]   s_awaddr;
  logic [2:0]    s_awprot;
  logic          s_awvalid;
  logic          s_awready;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_wvalid;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready;
  logic [31:0]   s_araddr;
  logic [2:0]    s_arprot;
  logic          s_arvalid;
  logic          s_arready;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready;
  logic [255:0]  regs_o;
  logic [7:0]    reg_wr_o;

  int            n_checks;
  int            n_errors;
  logic [31:0]   exp_regs [8];
  logic [1:0]    exp_oor_resp;

  axi4_lite_reg_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awprot  (s_awprot),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arprot  (s_arprot),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .regs_o    (regs_o),
    .reg_wr_o  (reg_wr_o)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_reg%0d", tag, k), {32'h0, regs_o[k*32 +: 32]}, {32'h0, exp_regs[k]});
    end
  endtask

  // Step past the next active edge so outputs have settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    for (int k = 0; k < 8; k++) exp_regs[k] = 32'h0;
`ifdef AXIL_REG_SLVERR_EN
    exp_oor_resp = 2'b10;
`else
    exp_oor_resp = 2'b00;
`endif
    rst       = 1'b1;
    s_awaddr  = 32'h0;
    s_awprot  = 3'b000;
    s_awvalid = 1'b0;
    s_wdata   = 32'h0;
    s_wstrb   = 4'h0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_araddr  = 32'h0;
    s_arprot  = 3'b000;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_awready", {63'h0, s_awready}, 64'h0);
    check("rst_wready",  {63'h0, s_wready},  64'h0);
    check("rst_arready", {63'h0, s_arready}, 64'h0);
    check("rst_bvalid",  {63'h0, s_bvalid},  64'h0);
    check("rst_rvalid",  {63'h0, s_rvalid},  64'h0);
    check("rst_rdata",   {32'h0, s_rdata},   64'h0);
    check("rst_regwr",   {56'h0, reg_wr_o},  64'h0);
    check_regs("rst");
    rst = 1'b0;
    #1;
    check("post_rst_awready", {63'h0, s_awready}, 64'h1);
    check("post_rst_arready", {63'h0, s_arready}, 64'h1);

    // 1: AW+W same cycle -> bvalid next cycle, reg1 written, pulse on bit 1
    s_awaddr = 32'h0000_0004; s_awvalid = 1'b1;
    s_wdata  = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_bready = 1'b1;
    tick();
    exp_regs[1] = 32'hDEAD_BEEF;
    check("t1_bvalid", {63'h0, s_bvalid}, 64'h1);
    check("t1_bresp",  {62'h0, s_bresp},  64'h0);
    check("t1_regwr",  {56'h0, reg_wr_o}, 64'h02);
    check_regs("t1");
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    check("t1_bvalid_clr", {63'h0, s_bvalid}, 64'h0);
    check("t1_regwr_clr",  {56'h0, reg_wr_o}, 64'h00);

    // 2: W first, AW three cycles later; strobe 0101 merges into zero
    s_wdata = 32'h1122_3344; s_wstrb = 4'b0101; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    #1;
    check("t2_wready_held", {63'h0, s_wready},  64'h0);
    check("t2_awready",     {63'h0, s_awready}, 64'h1);
    check("t2_no_bvalid",   {63'h0, s_bvalid},  64'h0);
    tick(); tick();
    check("t2_reg2_before", {32'h0, regs_o[95:64]}, 64'h0);
    s_awaddr = 32'h0000_0008; s_awvalid = 1'b1;
    tick();
    exp_regs[2] = 32'h0022_0044;
    check("t2_bvalid", {63'h0, s_bvalid}, 64'h1);
    check("t2_regwr",  {56'h0, reg_wr_o}, 64'h04);
    check_regs("t2");
    s_awvalid = 1'b0;
    tick();

    // 3: read reg1 with rready low for 5 cycles
    s_araddr = 32'h0000_0004; s_arvalid = 1'b1; s_rready = 1'b0;
    tick();
    s_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_rvalid",  {63'h0, s_rvalid},  64'h1);
      check("t3_rdata",   {32'h0, s_rdata},   64'hDEAD_BEEF);
      check("t3_arready", {63'h0, s_arready}, 64'h0);
      tick();
    end
    check("t3_rresp", {62'h0, s_rresp}, 64'h0);
    s_rready = 1'b1;
    tick();
    check("t3_rvalid_clr",  {63'h0, s_rvalid},  64'h0);
    check("t3_arready_set", {63'h0, s_arready}, 64'h1);

    // 4: out-of-range write and read at 0x20
    s_awaddr = 32'h0000_0020; s_awvalid = 1'b1;
    s_wdata  = 32'h0000_0001; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("t4_bvalid", {63'h0, s_bvalid}, 64'h1);
    check("t4_bresp",  {62'h0, s_bresp},  {62'h0, exp_oor_resp});
    check("t4_regwr",  {56'h0, reg_wr_o}, 64'h00);
    check_regs("t4");
    tick();
    s_araddr = 32'h0000_0020; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    check("t4_rvalid", {63'h0, s_rvalid}, 64'h1);
    check("t4_rdata",  {32'h0, s_rdata},  64'h0);
    check("t4_rresp",  {62'h0, s_rresp},  {62'h0, exp_oor_resp});
    tick();

    // 5: same-edge read and write of reg3 returns the old value
    s_awaddr = 32'h0000_000C; s_awvalid = 1'b1;
    s_wdata  = 32'h0000_0005; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    exp_regs[3] = 32'h5;
    tick();
    s_awaddr = 32'h0000_000C; s_awvalid = 1'b1;
    s_wdata  = 32'h0000_0009; s_wvalid = 1'b1;
    s_araddr = 32'h0000_000C; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    exp_regs[3] = 32'h9;
    check("t5_rdata_old", {32'h0, s_rdata}, 64'h5);
    check("t5_regwr",     {56'h0, reg_wr_o}, 64'h08);
    check_regs("t5");
    tick();
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    check("t5_rdata_new", {32'h0, s_rdata}, 64'h9);
    tick();

    // 6: reset while bvalid is pending
    s_bready = 1'b0;
    s_awaddr = 32'h0000_0004; s_awvalid = 1'b1;
    s_wdata  = 32'h1234_5678; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    exp_regs[1] = 32'h1234_5678;
    tick();
    check("t6_bvalid_hold", {63'h0, s_bvalid}, 64'h1);
    check_regs("t6_pre");
    rst = 1'b1;
    #1;
    check("t6_awready_rst", {63'h0, s_awready}, 64'h0);
    check("t6_arready_rst", {63'h0, s_arready}, 64'h0);
    tick();
    for (int k = 0; k < 8; k++) exp_regs[k] = 32'h0;
    check("t6_bvalid_clr", {63'h0, s_bvalid}, 64'h0);
    check("t6_wready_rst", {63'h0, s_wready}, 64'h0);
    check_regs("t6_post");
    rst = 1'b0;
    #1;
    check("t6_awready_up", {63'h0, s_awready}, 64'h1);
    check("t6_wready_up",  {63'h0, s_wready},  64'h1);
    check("t6_arready_up", {63'h0, s_arready}, 64'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_axi4_lite_reg_slave
